// File: rtl/esc_pkg.sv
// Constants and types shared by the ESC PWM drive and the ESC PWM decoder.
package esc_pkg;

  localparam int unsigned ESC_MIN_CNT     = 6250;
  localparam int unsigned ESC_SCALE       = 3;
  localparam int unsigned ESC_TIMEOUT_CYC = 1_000_000;
  localparam int unsigned ESC_SPEED_W     = 11;
  localparam int unsigned ESC_NUM_W       = 14;

  typedef logic [ESC_SPEED_W-1:0] speed_t;

  typedef enum logic [1:0] {IDLE, HIGH, DIV, DONE} esc_dec_state_t;

  // Longest legal high time: MIN_CNT plus SCALE clocks for every SPEED LSB.
  function automatic int unsigned esc_max_cnt(input int unsigned min_cnt, input int unsigned scale);
    return min_cnt + scale * ((1 << ESC_SPEED_W) - 1);
  endfunction

endpackage

// File: rtl/esc_div_seq.sv
// Restoring divider by the constant SCALE: 14-bit numerator, 11-bit quotient, one bit per clock
// MSB first; done_o marks the 11th busy cycle, where quot_o carries the complete quotient.
module esc_div_seq
  import esc_pkg::*;
#(
  parameter int unsigned SCALE = ESC_SCALE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [ESC_NUM_W-1:0] num_i,
  output logic                 busy_o,
  output logic                 done_o,
  output speed_t               quot_o
);

  localparam logic [15:0] DVS_INIT = 16'(SCALE << (ESC_SPEED_W - 1));

  logic [ESC_NUM_W-1:0]   rem_q, rem_d;
  logic [15:0]            dvs_q, dvs_d;
  logic [ESC_SPEED_W-2:0] quot_q, quot_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   ge;
  speed_t                 quot_step;

  assign ge        = ({2'b00, rem_q} >= dvs_q);
  assign quot_step = {quot_q, ge};

  always_comb begin
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      rem_d  = num_i;
      dvs_d  = DVS_INIT;
      quot_d = '0;
      cnt_d  = 4'(ESC_SPEED_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (ge) begin
        rem_d = rem_q - dvs_q[ESC_NUM_W-1:0];
      end
      dvs_d  = dvs_q >> 1;
      quot_d = quot_step[ESC_SPEED_W-2:0];
      cnt_d  = cnt_q - 4'd1;
      if (cnt_q == 4'd0) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == 4'd0);
  assign quot_o = quot_step;

endmodule

// File: rtl/esc_pwm_decoder.sv
// Measures the high time of an ESC PWM pulse and recovers SPEED = (high_cnt - MIN_CNT) / SCALE.
// Define ESC_DEC_TIMEOUT_EN to add the loss-of-signal timeout (los output).
module esc_pwm_decoder
  import esc_pkg::*;
#(
  parameter int unsigned MIN_CNT     = ESC_MIN_CNT,
  parameter int unsigned SCALE       = ESC_SCALE,
  parameter int unsigned TIMEOUT_CYC = ESC_TIMEOUT_CYC
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   PWM,
  output speed_t SPEED,
  output logic   vld,
  output logic   err,
  output logic   los
);

  localparam int unsigned MAX_CNT   = esc_max_cnt(MIN_CNT, SCALE);
  localparam logic [15:0] MIN_CNT16 = 16'(MIN_CNT);
  localparam logic [15:0] MAX_CNT16 = 16'(MAX_CNT);

  if (MAX_CNT >= 65536 || SCALE == 0) begin : g_bad_cfg
    $error("esc_pwm_decoder: MIN_CNT + SCALE*2047 must be below 2^16 and SCALE nonzero");
  end

  logic       sync1_q, pwm_s_q, prev_q;
  logic [1:0] fill_q;
  logic       rise;

  // The synchronizer flops start at 0, so prev stays high until they hold real samples;
  // otherwise a pulse already high at reset release would look like a fresh rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      pwm_s_q <= 1'b0;
      prev_q  <= 1'b1;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= PWM;
      pwm_s_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      prev_q  <= fill_q[1] ? pwm_s_q : 1'b1;
    end
  end

  assign rise = pwm_s_q & ~prev_q;

  esc_dec_state_t       state_q, state_d;
  logic [15:0]          high_cnt_q, high_cnt_d;
  speed_t               speed_q, speed_d, result;
  logic                 vld_q, vld_d, err_q, err_d;
  logic                 div_start, div_busy, div_done;
  logic [ESC_NUM_W-1:0] div_num;
  speed_t               div_quot;
  logic                 los_now;

  esc_div_seq #(.SCALE(SCALE)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(div_start),
    .num_i  (div_num),
    .busy_o (div_busy),
    .done_o (div_done),
    .quot_o (div_quot)
  );

`ifdef ESC_DEC_TIMEOUT_EN
  logic [19:0] to_cnt_q;
  logic        los_q, los_d, to_hit;

  if (TIMEOUT_CYC >= (1 << 20) || TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("esc_pwm_decoder: TIMEOUT_CYC must fit the 20-bit timeout counter");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      los_q    <= 1'b0;
    end else begin
      if (rise) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != 20'hFFFFF) begin
        to_cnt_q <= to_cnt_q + 20'd1;
      end
      los_q <= los_d;
    end
  end

  // A rise in the same cycle restarts the count, so it must not be swallowed by the abort.
  assign to_hit  = (to_cnt_q >= 20'(TIMEOUT_CYC)) && !rise;
  assign los_now = los_q;
`else
  assign los_now = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    high_cnt_d = high_cnt_q;
    speed_d    = speed_q;
    vld_d      = 1'b0;
    err_d      = 1'b0;
    result     = '0;
    div_start  = 1'b0;
    div_num    = '0;
`ifdef ESC_DEC_TIMEOUT_EN
    los_d      = los_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          high_cnt_d = 16'd1;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (pwm_s_q) begin
          if (high_cnt_q != 16'hFFFF) begin
            high_cnt_d = high_cnt_q + 16'd1;
          end
        end else if (high_cnt_q < MIN_CNT16) begin
          vld_d   = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (high_cnt_q > MAX_CNT16) begin
          result  = '1;
          vld_d   = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          div_start = 1'b1;
          div_num   = ESC_NUM_W'(high_cnt_q - MIN_CNT16);
          state_d   = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          result  = div_quot;
          vld_d   = 1'b1;
          state_d = DONE;
        end else if (!div_busy) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // While signal is lost SPEED is pinned to 0; only a clean pulse may move it again.
    if (vld_d && !(err_d && los_now)) begin
      speed_d = result;
    end

`ifdef ESC_DEC_TIMEOUT_EN
    if (vld_d && !err_d) begin
      los_d = 1'b0;
    end
    if (to_hit) begin
      state_d   = IDLE;
      speed_d   = '0;
      vld_d     = 1'b0;
      err_d     = 1'b0;
      div_start = 1'b0;
      los_d     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      high_cnt_q <= '0;
      speed_q    <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      high_cnt_q <= high_cnt_d;
      speed_q    <= speed_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
    end
  end

  assign SPEED = speed_q;
  assign vld   = vld_q;
  assign err   = err_q;
  assign los   = los_now;

endmodule

// File: tb/tb_esc_pwm_decoder.sv
// Self-checking bench for esc_pwm_decoder: table of pulses scored against a queue of expected
// results (value, err, exact vld cycle), plus reset and loss-of-signal sequences.
module tb_esc_pwm_decoder;
  import esc_pkg::*;

  localparam int unsigned TB_TIMEOUT = 15000;

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  logic   PWM   = 1'b0;
  speed_t SPEED;
  logic   vld, err, los;

  always #5 clk = ~clk;

  esc_pwm_decoder #(
    .MIN_CNT    (6250),
    .SCALE      (3),
    .TIMEOUT_CYC(TB_TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .PWM  (PWM),
    .SPEED(SPEED),
    .vld  (vld),
    .err  (err),
    .los  (los)
  );

  typedef struct {
    int          high;
    int          low;
    logic [10:0] speed;
    logic        err;
  } vec_t;

  typedef struct {
    logic [10:0] speed;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_vld = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Scoreboard side: every vld strobe pops one expectation.
  always @(negedge clk) begin
    if (rst_n && vld) begin
      n_vld++;
      if (sb_q.size() == 0) begin
        check("unexpected_vld", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("txn cyc=%0d SPEED=0x%03h err=%b los=%b | want 0x%03h err=%b at cyc %0d",
                 cyc, SPEED, err, los, e.speed, e.err, e.cyc);
        check("speed", int'(SPEED), int'(e.speed));
        check("err", int'(err), int'(e.err));
        check("vld_cycle", cyc, e.cyc);
      end
    end else if (rst_n && err) begin
      check("err_without_vld", 1, 0);
    end
  end

  // Rising edge of PWM in cycle c0, falling edge after 'high' cycles; result due 2 sync
  // cycles later plus 1 (out of range) or 12 (divide) cycles.
  task automatic pulse(input int high, input int low, input logic [10:0] es, input logic ee);
    exp_t e;
    @(posedge clk); #1;
    PWM = 1'b1;
    repeat (high) @(posedge clk);
    #1;
    PWM = 1'b0;
    e.speed = es;
    e.err   = ee;
    e.cyc   = cyc + 2 + (ee ? 1 : 12);
    sb_q.push_back(e);
    repeat (low) @(posedge clk);
    #1;
  endtask

  initial begin
    #(150_000 * 10);
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   exp_vld;
    int   t_f;

    tbl[0] = '{high: 6000,  low: 100, speed: 11'h000, err: 1'b1};
    tbl[1] = '{high: 7000,  low: 100, speed: 11'd250, err: 1'b0};
    tbl[2] = '{high: 6250,  low: 100, speed: 11'h000, err: 1'b0};
    tbl[3] = '{high: 9322,  low: 100, speed: 11'h400, err: 1'b0};
    tbl[4] = '{high: 12391, low: 100, speed: 11'h7FF, err: 1'b0};
    tbl[5] = '{high: 12392, low: 100, speed: 11'h7FF, err: 1'b1};
    tbl[6] = '{high: 9324,  low: 100, speed: 11'h400, err: 1'b0};
    exp_vld = 0;

    // Reset with PWM already high: that pulse must never be measured.
    rst_n = 1'b0;
    PWM   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_speed", int'(SPEED), 0);
    check("reset_vld", int'(vld), 0);
    check("reset_err", int'(err), 0);
    check("reset_los", int'(los), 0);
    rst_n = 1'b1;
    repeat (3000) @(posedge clk);
    #1;
    PWM = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("partial_pulse_no_vld", n_vld, 0);
    check("partial_pulse_speed", int'(SPEED), 0);

    for (int i = 0; i < 7; i++) begin
      pulse(tbl[i].high, tbl[i].low, tbl[i].speed, tbl[i].err);
      exp_vld++;
    end
    check("table_sb_drained", sb_q.size(), 0);
    check("table_vld_count", n_vld, exp_vld);

`ifdef ESC_DEC_TIMEOUT_EN
    begin
      int waited;
      waited = 0;
      while (los !== 1'b1 && waited < 20000) begin
        @(posedge clk); #1;
        waited++;
      end
    end
    check("los_set", int'(los), 1);
    check("los_speed_forced_0", int'(SPEED), 0);
    pulse(9322, 100, 11'h400, 1'b0);
    exp_vld++;
    check("los_cleared", int'(los), 0);
`else
    repeat (2000) @(posedge clk);
    #1;
    check("los_const_0", int'(los), 0);
    check("speed_held", int'(SPEED), 'h400);
`endif

    // Reset in the middle of the divide: abort, no vld, SPEED back to 0.
    @(posedge clk); #1;
    PWM = 1'b1;
    repeat (6250) @(posedge clk);
    #1;
    PWM = 1'b0;
    t_f = cyc;
    while (cyc < t_f + 7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #2;
    check("middiv_rst_speed", int'(SPEED), 0);
    check("middiv_rst_vld", int'(vld), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("middiv_no_vld", n_vld, exp_vld);
    check("middiv_speed", int'(SPEED), 0);
    check("final_sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
